// File: rtl/keypad_multitap_scanner.sv
// Matrix keypad scanner with debounce and phone-style multi-tap letter entry.
// Optional timeout auto-commit of the pending letter: define MULTITAP_AUTOCOMMIT_EN.
module keypad_multitap_scanner #(
  parameter int ROWS            = 4,
  parameter int COLS            = 4,
  parameter int LETTERS_PER_KEY = 4,
  parameter int SCAN_DIV        = 4,
  parameter int DEBOUNCE        = 5,
  parameter int TAP_TIMEOUT     = 150
) (
  input  logic            clk,
  input  logic            rst,
  output logic [COLS-1:0] col_out,
  input  logic [ROWS-1:0] row_in,
  output logic [7:0]      pending,
  output logic [7:0]      letter,
  output logic            letter_valid,
  output logic            submit,
  output logic            delete,
  output logic            error
);

  localparam int NKEYS = ROWS * COLS;
  localparam int KW    = $clog2(NKEYS);
  localparam int CW    = $clog2(COLS);
  localparam int TW    = $clog2(LETTERS_PER_KEY);
  localparam int DIVW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DBW   = $clog2(DEBOUNCE + 1);
  localparam int NGRP  = (26 + LETTERS_PER_KEY - 1) / LETTERS_PER_KEY;

  typedef enum logic [1:0] {S_SCAN, S_DEB_PRESS, S_HELD, S_DEB_REL} state_e;

  state_e          state_q, state_d;
  logic [ROWS-1:0] row_q, cap_q, cap_d;
  logic [CW-1:0]   col_q, col_d, samp_col_q;
  logic [DIVW-1:0] div_q, div_d;
  logic [DBW-1:0]  cnt_q, cnt_d;
  logic            mt_vld_q, mt_vld_d;
  logic [KW-1:0]   mt_key_q, mt_key_d;
  logic [TW-1:0]   mt_tap_q, mt_tap_d;
  logic [7:0]      letter_q, letter_d;
  logic            lv_q, lv_d, sub_q, sub_d, del_q, del_d, err_q, err_d;
  logic            key_evt, ghost_evt;
  logic [7:0]      pend_ascii;
  int              row_idx, key_idx, grp_size;

  // samp_col_q is the column that produced the value now sitting in row_q.
  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    div_d     = div_q;
    cnt_d     = cnt_q;
    cap_d     = cap_q;
    key_evt   = 1'b0;
    ghost_evt = 1'b0;
    case (state_q)
      S_SCAN: begin
        if (row_q != '0) begin
          state_d = S_DEB_PRESS;
          cap_d   = row_q;
          col_d   = samp_col_q;
          cnt_d   = '0;
          div_d   = '0;
        end else if (div_q == DIVW'(SCAN_DIV - 1)) begin
          div_d = '0;
          col_d = (col_q == CW'(COLS - 1)) ? '0 : col_q + 1'b1;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_DEB_PRESS: begin
        if (samp_col_q == col_q) begin
          if (row_q != cap_q) begin
            state_d = S_SCAN;
            div_d   = '0;
          end else if (cnt_q == DBW'(DEBOUNCE - 1)) begin
            state_d = S_HELD;
            if ($countones(cap_q) == 1) key_evt = 1'b1;
            else ghost_evt = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_HELD: begin
        if (row_q == '0) begin
          state_d = S_DEB_REL;
          cnt_d   = '0;
        end
      end
      default: begin
        if (row_q != '0) begin
          state_d = S_HELD;
        end else if (cnt_q == DBW'(DEBOUNCE - 1)) begin
          state_d = S_SCAN;
          div_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    row_idx = 0;
    for (int i = 0; i < ROWS; i++) begin
      if (cap_q[i]) row_idx = i;
    end
    key_idx  = row_idx * COLS + int'(col_q);
    grp_size = 26 - int'(mt_key_q) * LETTERS_PER_KEY;
    if (grp_size > LETTERS_PER_KEY) grp_size = LETTERS_PER_KEY;
    pend_ascii = 8'h41 + 8'(mt_key_q) * 8'(LETTERS_PER_KEY) + 8'(mt_tap_q);
  end

`ifdef MULTITAP_AUTOCOMMIT_EN
  localparam int TMW = $clog2(TAP_TIMEOUT + 1);
  logic [TMW-1:0] tmr_q, tmr_d;
`endif

  always_comb begin
    mt_vld_d = mt_vld_q;
    mt_key_d = mt_key_q;
    mt_tap_d = mt_tap_q;
    letter_d = letter_q;
    lv_d     = 1'b0;
    sub_d    = 1'b0;
    del_d    = 1'b0;
    err_d    = ghost_evt;
    if (key_evt) begin
      if (key_idx == NKEYS - 1) begin
        if (mt_vld_q) begin
          lv_d     = 1'b1;
          letter_d = pend_ascii;
        end
        sub_d    = 1'b1;
        mt_vld_d = 1'b0;
      end else if (key_idx == NKEYS - 2) begin
        if (mt_vld_q) mt_vld_d = 1'b0;
        else del_d = 1'b1;
      end else if (key_idx < NGRP) begin
        if (mt_vld_q && mt_key_q == KW'(key_idx)) begin
          mt_tap_d = (int'(mt_tap_q) + 1 >= grp_size) ? '0 : mt_tap_q + 1'b1;
        end else begin
          if (mt_vld_q) begin
            lv_d     = 1'b1;
            letter_d = pend_ascii;
          end
          mt_vld_d = 1'b1;
          mt_key_d = KW'(key_idx);
          mt_tap_d = '0;
        end
      end else begin
        err_d = 1'b1;
      end
    end
`ifdef MULTITAP_AUTOCOMMIT_EN
    tmr_d = tmr_q;
    if (key_evt) begin
      tmr_d = '0;
    end else if (state_q == S_SCAN && mt_vld_q && tmr_q != TMW'(TAP_TIMEOUT)) begin
      tmr_d = tmr_q + 1'b1;
      if (tmr_q == TMW'(TAP_TIMEOUT - 1)) begin
        lv_d     = 1'b1;
        letter_d = pend_ascii;
        mt_vld_d = 1'b0;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_SCAN;
      row_q      <= '0;
      cap_q      <= '0;
      col_q      <= '0;
      samp_col_q <= '0;
      div_q      <= '0;
      cnt_q      <= '0;
      mt_vld_q   <= 1'b0;
      mt_key_q   <= '0;
      mt_tap_q   <= '0;
      letter_q   <= 8'h00;
      lv_q       <= 1'b0;
      sub_q      <= 1'b0;
      del_q      <= 1'b0;
      err_q      <= 1'b0;
`ifdef MULTITAP_AUTOCOMMIT_EN
      tmr_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      row_q      <= row_in;
      cap_q      <= cap_d;
      col_q      <= col_d;
      samp_col_q <= col_q;
      div_q      <= div_d;
      cnt_q      <= cnt_d;
      mt_vld_q   <= mt_vld_d;
      mt_key_q   <= mt_key_d;
      mt_tap_q   <= mt_tap_d;
      letter_q   <= letter_d;
      lv_q       <= lv_d;
      sub_q      <= sub_d;
      del_q      <= del_d;
      err_q      <= err_d;
`ifdef MULTITAP_AUTOCOMMIT_EN
      tmr_q      <= tmr_d;
`endif
    end
  end

  always_comb begin
    col_out        = '0;
    col_out[col_q] = 1'b1;
  end

  assign pending      = mt_vld_q ? pend_ascii : 8'h00;
  assign letter       = letter_q;
  assign letter_valid = lv_q;
  assign submit       = sub_q;
  assign delete       = del_q;
  assign error        = err_q;

endmodule

// File: tb/tb_keypad_multitap_scanner.sv
// Directed bench for keypad_multitap_scanner: a keypad matrix model drives row_in
// from col_out; strobes are tallied on the falling edge and compared per step.
module tb_keypad_multitap_scanner;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] col_out;
  logic [3:0] row_in;
  logic [7:0] pending, letter;
  logic       letter_valid, submit, delete, error;

  always #5 clk = ~clk;

  keypad_multitap_scanner #(
    .ROWS(4), .COLS(4), .LETTERS_PER_KEY(4), .SCAN_DIV(1), .DEBOUNCE(2), .TAP_TIMEOUT(20)
  ) dut (
    .clk(clk), .rst(rst), .col_out(col_out), .row_in(row_in),
    .pending(pending), .letter(letter), .letter_valid(letter_valid),
    .submit(submit), .delete(delete), .error(error)
  );

  // Keypad matrix model
  logic       key_on, ghost_on;
  int         key_r, key_c;
  logic [3:0] raw_row;

  always_comb begin
    row_in = raw_row;
    if (key_on && col_out[key_c]) row_in[key_r] = 1'b1;
    if (ghost_on && col_out[0]) row_in = row_in | 4'b0011;
  end

  int n_lv = 0, n_sub = 0, n_del = 0, n_err = 0, n_both = 0;
  logic [7:0] last_letter = 8'h00;

  always @(negedge clk) begin
    if (!rst) begin
      if (letter_valid) begin
        n_lv++;
        last_letter = letter;
      end
      if (submit) n_sub++;
      if (delete) n_del++;
      if (error) n_err++;
      if (letter_valid && submit) n_both++;
    end
  end

  int n_chk = 0, n_fail = 0;
  int b_lv, b_sub, b_del, b_err, b_both;

  task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic snap();
    b_lv = n_lv; b_sub = n_sub; b_del = n_del; b_err = n_err; b_both = n_both;
  endtask

  task automatic tap(input int r, input int c);
    key_r  = r;
    key_c  = c;
    key_on = 1'b1;
    cyc(14);
    key_on = 1'b0;
    cyc(10);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; key_on = 1'b0; ghost_on = 1'b0; raw_row = 4'b0000; key_r = 0; key_c = 0;
    cyc(3);
    @(negedge clk);
    chk("rst_col", 16'(col_out), 16'h1);
    chk("rst_pending", 16'(pending), 16'h00);
    chk("rst_letter", 16'(letter), 16'h00);
    chk("rst_strobes", 16'({letter_valid, submit, delete, error}), 16'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    cyc(2);

    // Single tap then SUBMIT
    snap();
    tap(0, 0);
    chk("tap0_pending", 16'(pending), 16'h41);
    chk("tap0_no_strobe", 16'((n_lv - b_lv) + (n_err - b_err)), 16'd0);
    snap();
    tap(3, 3);
    chk("sub_lv", 16'(n_lv - b_lv), 16'd1);
    chk("sub_sub", 16'(n_sub - b_sub), 16'd1);
    chk("sub_same_cycle", 16'(n_both - b_both), 16'd1);
    chk("sub_letter", 16'(letter), 16'h41);
    chk("sub_pending", 16'(pending), 16'h00);

    // Same-key cycling, commit by different key
    snap();
    tap(0, 3);
    tap(0, 3);
    chk("cyc_pending", 16'(pending), 16'h4E);
    chk("cyc_no_lv", 16'(n_lv - b_lv), 16'd0);
    tap(0, 0);
    chk("cyc_commit_lv", 16'(n_lv - b_lv), 16'd1);
    chk("cyc_commit_strobe_val", 16'(last_letter), 16'h4E);
    chk("cyc_letter", 16'(letter), 16'h4E);
    chk("cyc_new_pending", 16'(pending), 16'h41);

    // DELETE with a pending letter discards it silently
    snap();
    tap(3, 2);
    chk("del_pend_pending", 16'(pending), 16'h00);
    chk("del_pend_no_del", 16'(n_del - b_del), 16'd0);
    chk("del_pend_no_lv", 16'(n_lv - b_lv), 16'd0);

    // Short group wrap: Y, Z, Y
    tap(1, 2);
    tap(1, 2);
    tap(1, 2);
    chk("wrap_pending", 16'(pending), 16'h59);
    snap();
    tap(3, 3);
    chk("wrap_sub_letter", 16'(letter), 16'h59);
    chk("wrap_sub_both", 16'(n_both - b_both), 16'd1);

    // Idle with a pending letter
    snap();
    tap(0, 2);
    chk("idle_tap_pending", 16'(pending), 16'h49);
    cyc(60);
`ifdef MULTITAP_AUTOCOMMIT_EN
    chk("idle_lv", 16'(n_lv - b_lv), 16'd1);
    chk("idle_letter", 16'(letter), 16'h49);
    chk("idle_pending", 16'(pending), 16'h00);
`else
    chk("idle_lv", 16'(n_lv - b_lv), 16'd0);
    chk("idle_letter", 16'(letter), 16'h59);
    chk("idle_pending", 16'(pending), 16'h49);
`endif
    snap();
    tap(3, 3);
    chk("idle_sub", 16'(n_sub - b_sub), 16'd1);
    chk("idle_sub_letter", 16'(letter), 16'h49);
    chk("idle_sub_pending", 16'(pending), 16'h00);

    // Ghost, unmapped key, glitch
    tap(0, 1);
    chk("e_pending", 16'(pending), 16'h45);
    snap();
    ghost_on = 1'b1;
    cyc(14);
    ghost_on = 1'b0;
    cyc(10);
    chk("ghost_err", 16'(n_err - b_err), 16'd1);
    chk("ghost_no_lv", 16'(n_lv - b_lv), 16'd0);
    chk("ghost_pending", 16'(pending), 16'h45);
    snap();
    tap(2, 2);
    chk("unmapped_err", 16'(n_err - b_err), 16'd1);
    chk("unmapped_pending", 16'(pending), 16'h45);
    snap();
    raw_row = 4'b0100;
    cyc(1);
    raw_row = 4'b0000;
    cyc(8);
    chk("glitch_events", 16'((n_err - b_err) + (n_lv - b_lv) + (n_del - b_del) + (n_sub - b_sub)), 16'd0);
    chk("glitch_pending", 16'(pending), 16'h45);

    // DELETE twice
    snap();
    tap(3, 2);
    chk("del1_pending", 16'(pending), 16'h00);
    chk("del1_no_del", 16'(n_del - b_del), 16'd0);
    tap(3, 2);
    chk("del2_del", 16'(n_del - b_del), 16'd1);

    // Reset mid-composition
    tap(0, 1);
    chk("pre_rst_pending", 16'(pending), 16'h45);
    snap();
    key_r = 0; key_c = 1; key_on = 1'b1;
    cyc(7);
    rst = 1'b1;
    cyc(2);
    @(negedge clk);
    chk("mrst_col", 16'(col_out), 16'h1);
    chk("mrst_pending", 16'(pending), 16'h00);
    chk("mrst_letter", 16'(letter), 16'h00);
    chk("mrst_strobes", 16'({letter_valid, submit, delete, error}), 16'h0);
    @(posedge clk); #1;
    key_on = 1'b0;
    cyc(2);
    rst = 1'b0;
    cyc(10);
    chk("mrst_no_lv", 16'(n_lv - b_lv), 16'd0);
    chk("mrst_pending_after", 16'(pending), 16'h00);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
